// File: rtl/miner_pkg.sv
// Shared types and sizes for the miner result transmit path.
// Pure declarations; no logic, no latency.
package miner_pkg;

    localparam int RESULT_W      = 288;
    localparam int PAYLOAD_BYTES = RESULT_W / 8;
    localparam int HASH_W        = 256;
    localparam int NONCE_W       = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEADER   = 2'd1,
        PAYLOAD  = 2'd2,
        CHECKSUM = 2'd3
    } txstate_t;

endpackage

// File: rtl/miner_result_shreg.sv
// 288-bit result holding register, loaded whole and emptied MSB byte first.
// Load/shift take effect at the next edge; bytes are read combinationally.
module miner_result_shreg
    import miner_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    input  logic                i_load,
    input  logic                i_shift,
    input  logic [RESULT_W-1:0] i_data,
    output logic [7:0]          o_msb_byte,
    output logic [7:0]          o_next_byte
);

    logic [RESULT_W-1:0] r_shift;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            r_shift <= {r_shift[RESULT_W-9:0], 8'h00};
        end
    end

    // o_next_byte is what o_msb_byte becomes after one shift.
    assign o_msb_byte  = r_shift[RESULT_W-1 -: 8];
    assign o_next_byte = r_shift[RESULT_W-9 -: 8];

endmodule

// File: rtl/miner_result_tx.sv
// Frames a captured miner result as header + 36 payload bytes + XOR checksum, one byte per transfer.
// First byte valid one cycle after a send_data rising edge; each byte is held until tx_ready accepts it.
module miner_result_tx #(
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter int         RESULT_W    = 288
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                send_data,
    input  logic [RESULT_W-1:0] tx_data,
    output logic [7:0]          tx_byte,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                frame_done,
    output logic                overflow,
    input  logic                clear_ovf
);
    import miner_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(PAYLOAD_BYTES - 1);

    txstate_t   r_state;
    txstate_t   w_state_nxt;
    logic       r_send_q;
    logic [5:0] r_cnt;
    logic [7:0] r_csum;
    logic [7:0] r_tx_byte;
    logic       r_tx_valid;
    logic       r_frame_done;
    logic       r_ovf;

    logic       w_start;
    logic       w_xfer;
    logic       w_load;
    logic       w_shift;
    logic [7:0] w_msb_byte;
    logic [7:0] w_next_byte;
    logic [5:0] w_cnt_nxt;
    logic [7:0] w_csum_nxt;
    logic [7:0] w_tx_byte_nxt;
    logic       w_tx_valid_nxt;
    logic       w_frame_done_nxt;
    logic       w_ovf_nxt;

    assign w_start = send_data & ~r_send_q;
    assign w_xfer  = r_tx_valid & tx_ready;

    miner_result_shreg u_shreg (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_load      (w_load),
        .i_shift     (w_shift),
        .i_data      (tx_data),
        .o_msb_byte  (w_msb_byte),
        .o_next_byte (w_next_byte)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_start) w_state_nxt = HEADER;
            HEADER:   if (w_xfer) w_state_nxt = PAYLOAD;
            PAYLOAD:  if (w_xfer && (r_cnt == LAST_IDX)) w_state_nxt = CHECKSUM;
            CHECKSUM: if (w_xfer) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_load           = 1'b0;
        w_shift          = 1'b0;
        w_cnt_nxt        = r_cnt;
        w_csum_nxt       = r_csum;
        w_tx_byte_nxt    = r_tx_byte;
        w_tx_valid_nxt   = r_tx_valid;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_load         = 1'b1;
                    w_cnt_nxt      = '0;
                    w_csum_nxt     = '0;
                    w_tx_byte_nxt  = HEADER_BYTE;
                    w_tx_valid_nxt = 1'b1;
                end
            end
            HEADER: begin
                if (w_xfer) w_tx_byte_nxt = w_msb_byte;
            end
            PAYLOAD: begin
                if (w_xfer) begin
                    w_shift    = 1'b1;
                    w_csum_nxt = r_csum ^ r_tx_byte;
                    // The checksum presented must already include the byte just sent.
                    if (r_cnt == LAST_IDX) begin
                        w_tx_byte_nxt = r_csum ^ r_tx_byte;
                    end else begin
                        w_cnt_nxt     = r_cnt + 6'd1;
                        w_tx_byte_nxt = w_next_byte;
                    end
                end
            end
            CHECKSUM: begin
                if (w_xfer) begin
                    w_tx_valid_nxt   = 1'b0;
                    w_frame_done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A drop beats a simultaneous clear so no lost result goes unreported.
    assign w_ovf_nxt = (w_start && (r_state != IDLE)) ? 1'b1 :
                       clear_ovf                       ? 1'b0 : r_ovf;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_send_q     <= 1'b0;
            r_cnt        <= '0;
            r_csum       <= '0;
            r_tx_byte    <= '0;
            r_tx_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_send_q     <= send_data;
            r_cnt        <= w_cnt_nxt;
            r_csum       <= w_csum_nxt;
            r_tx_byte    <= w_tx_byte_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_ovf        <= w_ovf_nxt;
        end
    end

    assign tx_byte    = r_tx_byte;
    assign tx_valid   = r_tx_valid;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_miner_result_tx.sv
// Bench for miner_result_tx: vector table, hand-written corner sequences, randomized frames vs a frame model.
module tb_miner_result_tx;

    logic         clk       = 1'b0;
    logic         n_rst     = 1'b0;
    logic         send_data = 1'b0;
    logic [287:0] tx_data   = '0;
    logic         tx_ready  = 1'b0;
    logic         clear_ovf = 1'b0;
    logic [7:0]   tx_byte;
    logic         tx_valid;
    logic         busy;
    logic         frame_done;
    logic         overflow;

    miner_result_tx dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .send_data  (send_data),
        .tx_data    (tx_data),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf)
    );

    always #5 clk = ~clk;

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    // Inputs change 1 time unit after posedge, so the negedge view is what the next edge will see.
    always @(negedge clk) begin
        if (n_rst && tx_valid && tx_ready) rx_q.push_back(tx_byte);
        if (n_rst && frame_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: header, the word's bytes MSB first, XOR of the payload bytes.
    task automatic make_frame(input logic [287:0] d);
        logic [7:0] cs;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        cs = 8'h00;
        for (int i = 0; i < 36; i++) begin
            b = d[287 - 8*i -: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);
    endtask

    task automatic run_frame(input logic [287:0] d, input int hold, input int stall_idx,
                             input int stall_len, input bit rnd_ready, input int resend_idx,
                             input bit resend_clr, input int rst_idx, output int done_cyc);
        int         cyc;
        int         stall_left;
        int         resend_cyc;
        int         nbad;
        bit         stalled;
        bit         resent;
        bit         prev_v;
        bit         prev_r;
        logic [7:0] prev_b;
        make_frame(d);
        rx_q.delete();
        done_cyc   = -1;
        tx_data    = d;
        send_data  = 1'b1;
        tx_ready   = 1'b1;
        cyc        = 0;
        stall_left = 0;
        resend_cyc = -10;
        stalled    = 1'b0;
        resent     = 1'b0;
        prev_v     = tx_valid;
        prev_r     = tx_ready;
        prev_b     = tx_byte;
        while (cyc < 400) begin
            step();
            cyc++;
            if (prev_v && !prev_r) begin
                check("stall_valid_held", tx_valid, 1);
                check("stall_byte_held", tx_byte, prev_b);
            end
            if (cyc == 1) begin
                check("hdr_latency_valid", tx_valid, 1);
                check("hdr_latency_byte", tx_byte, 8'hA5);
                check("busy_in_frame", busy, 1);
            end
            if (cyc == hold) send_data = 1'b0;
            if (cyc == resend_cyc + 1) begin
                send_data = 1'b0;
                clear_ovf = 1'b0;
            end
            if (frame_done) begin
                done_cyc = cyc;
                break;
            end
            if (rst_idx >= 0 && rx_q.size() == rst_idx) begin
                check("ovf_before_reset", overflow, 1);
                n_rst = 1'b0;
                step();
                check("rst_tx_valid", tx_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_overflow", overflow, 0);
                check("rst_frame_done", frame_done, 0);
                n_rst     = 1'b1;
                send_data = 1'b0;
                clear_ovf = 1'b0;
                tx_ready  = 1'b1;
                return;
            end
            if (resend_idx >= 0 && !resent && rx_q.size() == resend_idx) begin
                send_data  = 1'b1;
                clear_ovf  = resend_clr;
                resent     = 1'b1;
                resend_cyc = cyc;
            end
            if (stall_left > 0) stall_left--;
            if (!stalled && stall_idx >= 0 && tx_valid && rx_q.size() == stall_idx) begin
                stalled    = 1'b1;
                stall_left = stall_len;
            end
            tx_ready = (stall_left > 0) ? 1'b0 :
                       rnd_ready        ? ($urandom_range(0, 3) != 0) : 1'b1;
            prev_v = tx_valid;
            prev_r = tx_ready;
            prev_b = tx_byte;
        end
        if (resent) begin
            send_data = 1'b0;
            clear_ovf = 1'b0;
        end
        tx_ready = 1'b1;
        if (done_cyc < 0) check("frame_done_timeout", 0, 1);
        check("frame_len", rx_q.size(), exp_q.size());
        nbad = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) nbad++;
        end
        check("frame_bytes_bad", nbad, 0);
    endtask

    typedef struct {
        logic [287:0] d;
        logic [7:0]   csum;
        logic [7:0]   first;
        logic [7:0]   last;
        int           stall_idx;
        int           exp_done;
    } vec_t;

    vec_t       vt[6];
    int         dc;
    int         d0;
    logic [287:0] rd;

    initial begin
        vt[0] = '{d: {255'h0, 1'b1, 32'hDEADBEEF}, csum: 8'h23, first: 8'h00, last: 8'hEF, stall_idx: -1, exp_done: 39};
        vt[1] = '{d: {255'h0, 1'b1, 32'hDEADBEEF}, csum: 8'h23, first: 8'h00, last: 8'hEF, stall_idx: 10, exp_done: 44};
        vt[2] = '{d: 288'h0,                         csum: 8'h00, first: 8'h00, last: 8'h00, stall_idx: -1, exp_done: 39};
        vt[3] = '{d: {288{1'b1}},                   csum: 8'h00, first: 8'hFF, last: 8'hFF, stall_idx: -1, exp_done: 39};
        vt[4] = '{d: {8'h12, 272'h0, 8'h34},         csum: 8'h26, first: 8'h12, last: 8'h34, stall_idx: -1, exp_done: 39};
        vt[5] = '{d: {8'h80, 248'h0, 32'h00000001},  csum: 8'h81, first: 8'h80, last: 8'h01, stall_idx: -1, exp_done: 39};

        n_rst = 1'b0;
        repeat (3) step();
        check("reset_tx_valid", tx_valid, 0);
        check("reset_tx_byte", tx_byte, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_overflow", overflow, 0);
        n_rst    = 1'b1;
        tx_ready = 1'b1;
        repeat (2) step();

        d0 = done_cnt;
        for (int v = 0; v < 6; v++) begin
            run_frame(vt[v].d, 1, vt[v].stall_idx, 5, 1'b0, -1, 1'b0, -1, dc);
            check("vec_done_cycle", dc, vt[v].exp_done);
            if (rx_q.size() == 38) begin
                check("vec_header", rx_q[0], 8'hA5);
                check("vec_first_payload", rx_q[1], vt[v].first);
                check("vec_last_payload", rx_q[36], vt[v].last);
                check("vec_checksum", rx_q[37], vt[v].csum);
            end
            step();
            check("vec_done_one_cycle", frame_done, 0);
            check("vec_idle_busy", busy, 0);
            step();
        end
        check("vec_done_count", done_cnt - d0, 6);
        check("vec_overflow", overflow, 0);

        // Held send_data: one frame only.
        d0 = done_cnt;
        run_frame(vt[0].d, 60, -1, 0, 1'b0, -1, 1'b0, -1, dc);
        repeat (25) step();
        send_data = 1'b0;
        repeat (3) step();
        check("held_no_extra_bytes", rx_q.size(), 38);
        check("held_one_frame", done_cnt - d0, 1);
        check("held_overflow", overflow, 0);

        // Second rising edge mid-payload is dropped.
        run_frame(vt[4].d, 1, -1, 0, 1'b0, 13, 1'b0, -1, dc);
        check("drop_overflow_set", overflow, 1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("clear_ovf", overflow, 0);

        // Drop coinciding with clear: overflow must still be set.
        run_frame(vt[5].d, 1, -1, 0, 1'b0, 20, 1'b1, -1, dc);
        check("set_wins_overflow", overflow, 1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("set_wins_clear", overflow, 0);

        // Rising edge sampled on the checksum transfer edge is also a drop.
        run_frame(vt[0].d, 1, -1, 0, 1'b0, 37, 1'b0, -1, dc);
        step();
        check("ckbyte_drop_overflow", overflow, 1);
        check("ckbyte_drop_no_frame", busy, 0);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        step();

        // Back-to-back: new start in the frame_done cycle.
        d0 = done_cnt;
        run_frame(vt[0].d, 1, -1, 0, 1'b0, -1, 1'b0, -1, dc);
        run_frame(vt[4].d, 1, -1, 0, 1'b0, -1, 1'b0, -1, dc);
        check("b2b_done_cycle", dc, 39);
        step();
        check("b2b_done_count", done_cnt - d0, 2);
        check("b2b_overflow", overflow, 0);

        // Reset mid-frame, then a fresh frame.
        d0 = done_cnt;
        run_frame(vt[0].d, 1, -1, 0, 1'b0, 13, 1'b0, 21, dc);
        repeat (5) step();
        check("rst_no_frame_done", done_cnt - d0, 0);
        check("rst_stays_idle", tx_valid, 0);
        run_frame(vt[5].d, 1, -1, 0, 1'b0, -1, 1'b0, -1, dc);
        check("post_rst_done_cycle", dc, 39);
        step();

        // Randomized data and backpressure.
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 9; w++) rd[w*32 +: 32] = $urandom;
            run_frame(rd, 1, $urandom_range(0, 37), $urandom_range(1, 6), 1'b1, -1, 1'b0, -1, dc);
            step();
            repeat ($urandom_range(0, 3)) step();
        end
        check("rand_overflow", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
